// File: rtl/sdram_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdram_rr_arbiter_pkg
// Shared definitions for the SDRAM round-robin arbiter:
//   state_t     - arbiter FSM state encoding (IDLE=0, REQ=1, RESP=2)
//   strb_width  - byte-strobe width for a given data width
// -----------------------------------------------------------------------------
package sdram_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_rr_arbiter_if
// Bundles the requester-side (s_*) and SDRAM-side (m_*) signals of the arbiter.
//   s_valid  NUM_REQ          per-requester request, held until its s_ready
//   s_ready  NUM_REQ          one-hot, one-cycle completion pulse
//   s_addr   NUM_REQ*ADDR_W   requester i at [i*ADDR_W +: ADDR_W]
//   s_wdata  NUM_REQ*DATA_W   requester i at [i*DATA_W +: DATA_W]
//   s_wstrb  NUM_REQ*STRB_W   byte strobes, all-zero means read
//   s_rdata  DATA_W           shared return data, valid with s_ready
//   m_valid/m_ready           request/completion handshake toward sys_sdram
//   m_addr/m_wdata/m_wstrb    latched request of the granted requester
//   m_rdata  DATA_W           sys_sdram read data, valid with m_ready
// Modports: master = arbiter view, slave = requesters + sys_sdram view.
// -----------------------------------------------------------------------------
interface sdram_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    import sdram_rr_arbiter_pkg::*;

    localparam int STRB_W = strb_width(DATA_W);

    logic [NUM_REQ-1:0]        s_valid;
    logic [NUM_REQ-1:0]        s_ready;
    logic [NUM_REQ*ADDR_W-1:0] s_addr;
    logic [NUM_REQ*DATA_W-1:0] s_wdata;
    logic [NUM_REQ*STRB_W-1:0] s_wstrb;
    logic [DATA_W-1:0]         s_rdata;

    logic                      m_valid;
    logic                      m_ready;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic [STRB_W-1:0]         m_wstrb;
    logic [DATA_W-1:0]         m_rdata;

    modport master (
        input  s_valid, s_addr, s_wdata, s_wstrb, m_ready, m_rdata,
        output s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb
    );

    modport slave (
        output s_valid, s_addr, s_wdata, s_wstrb, m_ready, m_rdata,
        input  s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb
    );

endinterface

// File: rtl/sdram_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection.
//   i_req   NUM_REQ  request vector
//   i_last  IDX_W    index granted last time; scanning starts at i_last+1
//   o_any   1        at least one request present
//   o_idx   IDX_W    winning index (meaningful only when o_any)
// The request vector is rotated so that i_last+1 lands at bit 0, the lowest
// set bit is found, and the position is rotated back.
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_idx
);
    int                 w_sh;
    int                 w_pos;
    logic [NUM_REQ-1:0] w_rot;

    always_comb begin
        w_sh  = (int'(i_last) + 1) % NUM_REQ;
        // Doubling the vector turns the rotate into a plain right shift.
        w_rot = NUM_REQ'({i_req, i_req} >> w_sh);
        w_pos = 0;
        // Descending scan so the lowest set bit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_pos = k;
        end
        o_idx = IDX_W'((w_pos + w_sh) % NUM_REQ);
    end

    assign o_any = |i_req;

endmodule

// File: rtl/sdram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_rr_arbiter
// Shares one sys_sdram request port between NUM_REQ requesters with
// round-robin priority and a single transaction in flight.
//   clk      clock
//   rst_n    asynchronous active-low reset (shared with sys_sdram)
//   bus      sdram_rr_arbiter_if.master: s_* requester side, m_* SDRAM side
//   o_grant  index of the current / last granted requester
//   o_busy   high while a transaction is in REQ or RESP
// Flow: IDLE picks a winner and latches its request into m_*; REQ holds m_*
// until m_ready; RESP shows the one-cycle s_ready pulse and returns to IDLE.
// -----------------------------------------------------------------------------
module sdram_rr_arbiter
    import sdram_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    sdram_rr_arbiter_if.master  bus,
    output logic [IDX_W-1:0]    o_grant,
    output logic                o_busy
);
    localparam int              STRB_W    = strb_width(DATA_W);
    // Reset grant points at the last requester so requester 0 is scanned first.
    localparam logic [IDX_W-1:0] GRANT_RST = IDX_W'(NUM_REQ - 1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_grant;
    logic                 r_busy;
    logic                 r_m_valid;
    logic [ADDR_W-1:0]    r_m_addr;
    logic [DATA_W-1:0]    r_m_wdata;
    logic [STRB_W-1:0]    r_m_wstrb;
    logic [NUM_REQ-1:0]   r_s_ready;
    logic [DATA_W-1:0]    r_s_rdata;

    logic                 w_any;
    logic [IDX_W-1:0]     w_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (bus.s_valid),
        .i_last  (r_grant),
        .o_any   (w_any),
        .o_idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= GRANT_RST;
            r_busy    <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_wstrb <= '0;
            r_s_ready <= '0;
            r_s_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_m_addr  <= bus.s_addr [int'(w_idx)*ADDR_W +: ADDR_W];
                        r_m_wdata <= bus.s_wdata[int'(w_idx)*DATA_W +: DATA_W];
                        r_m_wstrb <= bus.s_wstrb[int'(w_idx)*STRB_W +: STRB_W];
                        r_grant   <= w_idx;
                        r_m_valid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Completion is taken even if the requester dropped
                    // s_valid meanwhile; there is no abort path.
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_s_rdata <= bus.m_rdata;
                        r_s_ready <= NUM_REQ'(1) << r_grant;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Return data is zeroed outside the pulse so a stale read
                    // value is never left on the shared bus.
                    r_s_ready <= '0;
                    r_s_rdata <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_m_valid <= 1'b0;
                    r_s_ready <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m_valid = r_m_valid;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.m_wstrb = r_m_wstrb;
    assign bus.s_ready = r_s_ready;
    assign bus.s_rdata = r_s_rdata;
    assign o_grant     = r_grant;
    assign o_busy      = r_busy;

endmodule
